// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer command path: frame constants, opcode and FSM encodings.
package la_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 7;

  typedef enum logic [1:0] {
    OP_TRIG  = 2'b00,
    OP_PRESC = 2'b01,
    OP_CTRL  = 2'b10,
    OP_ILL   = 2'b11
  } opcode_e;

  // Order matters: the parser advances CMD..CHK by incrementing the encoding.
  typedef enum logic [2:0] {
    P_SYNC = 3'd0,
    P_CMD  = 3'd1,
    P_D3   = 3'd2,
    P_D2   = 3'd3,
    P_D1   = 3'd4,
    P_D0   = 3'd5,
    P_CHK  = 3'd6
  } pstate_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rxstate_e;

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [31:0] data);
    return cmd ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
  endfunction
endpackage

// File: rtl/uart_cmd_rx_if.sv
// Host-side UART line plus the per-channel control outputs of the command receiver.
interface uart_cmd_rx_if #(
  parameter int CH_NO = 4
);
  logic                rx;
  logic [CH_NO*32-1:0] trig_cnt;
  logic [CH_NO*32-1:0] prescaler;
  logic [CH_NO-1:0]    tog_pulse;
  logic [CH_NO-1:0]    ch_rst_n;
  logic                cmd_ok;
  logic                cmd_err;

  modport master (
    output rx,
    input  trig_cnt, prescaler, tog_pulse, ch_rst_n, cmd_ok, cmd_err
  );

  modport slave (
    input  rx,
    output trig_cnt, prescaler, tog_pulse, ch_rst_n, cmd_ok, cmd_err
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchronizer, start-bit glitch rejection, mid-bit sampling.
module uart_rx_byte
  import la_pkg::*;
#(
  parameter int BAUD_PRESCALER = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);
  localparam int            CW   = $clog2(BAUD_PRESCALER);
  localparam logic [CW-1:0] FULL = CW'(BAUD_PRESCALER - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_PRESCALER / 2 - 1);

  // [0],[1] synchronizer, [2] history for falling-edge detect; all idle high.
  logic [2:0]    r_sync;
  rxstate_e      r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic          r_valid;
  logic          r_ferr;

  logic w_rx;
  logic w_fall;
  assign w_rx   = r_sync[1];
  assign w_fall = r_sync[2] & ~r_sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 3'b111;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[1:0], i_rx};
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (w_fall) begin
            r_state <= RX_START;
            r_cnt   <= HALF;
          end
        end
        RX_START: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
          else if (w_rx)   r_state <= RX_IDLE;
          else begin
            r_state <= RX_DATA;
            r_cnt   <= FULL;
            r_bit   <= '0;
          end
        end
        RX_DATA: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
          else begin
            r_sh  <= {w_rx, r_sh[7:1]};
            r_cnt <= FULL;
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
          else begin
            r_state <= RX_IDLE;
            if (w_rx) r_valid <= 1'b1;
            else      r_ferr  <= 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_byte       = r_sh;
  assign o_byte_valid = r_valid;
  assign o_frame_err  = r_ferr;
endmodule

// File: rtl/uart_cmd_rx.sv
// Command receiver: parses 7-byte A5-framed commands and drives per-channel trigger/prescaler
// registers and one-cycle toggle/reset strobes.
module uart_cmd_rx
  import la_pkg::*;
#(
  parameter int          CH_NO          = 4,
  parameter int          BAUD_PRESCALER = 434,
  parameter int          TIMEOUT_BITS   = 20,
  parameter logic [31:0] TRIG_DEFAULT   = 32'h20,
  parameter logic [31:0] PRESC_DEFAULT  = 32'hC350
) (
  input  logic          i_clk,
  input  logic          _rst,
  uart_cmd_rx_if.slave  bus
);
  localparam int TO_CYC = TIMEOUT_BITS * BAUD_PRESCALER;
  localparam int TW     = $clog2(TO_CYC + 1);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_frame_err;

  uart_rx_byte #(.BAUD_PRESCALER(BAUD_PRESCALER)) u_rx (
    .i_clk        (i_clk),
    .i_rst_n      (_rst),
    .i_rx         (bus.rx),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
  );

  pstate_e                   r_state;
  logic [7:0]                r_cmd;
  logic [31:0]               r_data;
  logic [TW-1:0]             r_to;
  logic [CH_NO-1:0][31:0]    r_trig;
  logic [CH_NO-1:0][31:0]    r_presc;
  logic [CH_NO-1:0]          r_tog;
  logic [CH_NO-1:0]          r_rst_n;
  logic                      r_ok;
  logic                      r_err;

  opcode_e    w_op;
  logic [1:0] w_ch;
  logic       w_timeout;
  logic       w_accept;

  assign w_op      = opcode_e'(r_cmd[7:6]);
  assign w_ch      = r_cmd[1:0];
  assign w_timeout = (r_to == TW'(TO_CYC - 1));
  assign w_accept  = (w_byte == frame_chk(r_cmd, r_data)) && (w_op != OP_ILL) &&
                     (32'(w_ch) < 32'(CH_NO));

  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      r_state <= P_SYNC;
      r_cmd   <= '0;
      r_data  <= '0;
      r_to    <= '0;
      r_trig  <= {CH_NO{TRIG_DEFAULT}};
      r_presc <= {CH_NO{PRESC_DEFAULT}};
      r_tog   <= '0;
      r_rst_n <= '1;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_tog   <= '0;
      r_rst_n <= '1;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      r_to    <= (r_state == P_SYNC || w_byte_valid) ? '0 : r_to + TW'(1);
      if (w_frame_err) begin
        r_state <= P_SYNC;
        r_err   <= 1'b1;
      end else if (w_byte_valid) begin
        case (r_state)
          P_SYNC: if (w_byte == SYNC_BYTE) r_state <= P_CMD;
          P_CMD: begin
            r_cmd   <= w_byte;
            r_state <= pstate_e'(r_state + 3'd1);
          end
          // Staging only; targets change solely on a good CHK byte.
          P_D3, P_D2, P_D1, P_D0: begin
            r_data  <= {r_data[23:0], w_byte};
            r_state <= pstate_e'(r_state + 3'd1);
          end
          P_CHK: begin
            r_state <= P_SYNC;
            if (w_accept) begin
              r_ok <= 1'b1;
              for (int c = 0; c < CH_NO; c++) begin
                if (c == int'(w_ch)) begin
                  case (w_op)
                    OP_TRIG:  r_trig[c]  <= r_data;
                    OP_PRESC: r_presc[c] <= r_data;
                    OP_CTRL: begin
                      r_tog[c]   <= r_data[0];
                      r_rst_n[c] <= ~r_data[1];
                    end
                    default: ;
                  endcase
                end
              end
            end else begin
              r_err <= 1'b1;
            end
          end
          default: r_state <= P_SYNC;
        endcase
      end else if (r_state != P_SYNC && w_timeout) begin
        r_state <= P_SYNC;
        r_err   <= 1'b1;
      end
    end
  end

  assign bus.trig_cnt  = r_trig;
  assign bus.prescaler = r_presc;
  assign bus.tog_pulse = r_tog;
  assign bus.ch_rst_n  = r_rst_n;
  assign bus.cmd_ok    = r_ok;
  assign bus.cmd_err   = r_err;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed frame table, hand-written corner sequences, randomized frames.
`timescale 1ns/1ps
module tb_uart_cmd_rx;
  import la_pkg::*;

  localparam int CH_NO = 4;
  localparam int BAUD  = 16;
  localparam int TOB   = 20;
  localparam int VW    = CH_NO * 32;

  localparam logic [VW-1:0] T_DEF = {CH_NO{32'h20}};
  localparam logic [VW-1:0] P_DEF = {CH_NO{32'h0000C350}};

  logic i_clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  uart_cmd_rx_if #(.CH_NO(CH_NO)) bus();

  uart_cmd_rx #(
    .CH_NO(CH_NO), .BAUD_PRESCALER(BAUD), .TIMEOUT_BITS(TOB),
    .TRIG_DEFAULT(32'h20), .PRESC_DEFAULT(32'hC350)
  ) dut (
    .i_clk (i_clk),
    ._rst  (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Observation of output events, sampled on the falling edge.
  int cyc = 0, ok_cnt = 0, err_cnt = 0, ok_cyc = 0, bad_cnt = 0;
  int tog_cnt[CH_NO];
  int rst_cnt[CH_NO];
  logic [VW-1:0] prev_trig, prev_presc;
  logic prev_rst = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (rst_n && prev_rst) begin
      if (bus.cmd_ok) begin
        ok_cnt <= ok_cnt + 1;
        ok_cyc <= cyc;
      end
      if (bus.cmd_err) err_cnt <= err_cnt + 1;
      for (int c = 0; c < CH_NO; c++) begin
        if (bus.tog_pulse[c])  tog_cnt[c] <= tog_cnt[c] + 1;
        if (!bus.ch_rst_n[c])  rst_cnt[c] <= rst_cnt[c] + 1;
      end
      if (!bus.cmd_ok && (bus.trig_cnt !== prev_trig || bus.prescaler !== prev_presc ||
                          bus.tog_pulse !== '0 || bus.ch_rst_n !== '1))
        bad_cnt <= bad_cnt + 1;
    end
    prev_trig  <= bus.trig_cnt;
    prev_presc <= bus.prescaler;
    prev_rst   <= rst_n;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string what, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", what, act, exp);
    end
  endtask

  int last_start = 0;

  task automatic send_bit(input logic v);
    bus.rx = v;
    repeat (BAUD) @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    last_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic send_frame(input logic [FRAME_LEN*8-1:0] f);
    for (int i = FRAME_LEN - 1; i >= 0; i--) send_byte(f[i*8 +: 8], 1'b1);
  endtask

  task automatic idle_bits(input int n);
    bus.rx = 1'b1;
    repeat (n * BAUD) @(posedge i_clk);
    #1;
  endtask

  int s_ok, s_err;
  int s_tog[CH_NO];
  int s_rst[CH_NO];

  task automatic snap();
    s_ok  = ok_cnt;
    s_err = err_cnt;
    for (int c = 0; c < CH_NO; c++) begin
      s_tog[c] = tog_cnt[c];
      s_rst[c] = rst_cnt[c];
    end
  endtask

  task automatic check_frame(input string nm, input int e_ok, input int e_err,
                             input logic [CH_NO-1:0] e_tog, input logic [CH_NO-1:0] e_rst,
                             input logic [VW-1:0] e_trig, input logic [VW-1:0] e_presc);
    logic [CH_NO*8-1:0] a_t, x_t, a_r, x_r;
    int lat;
    for (int c = 0; c < CH_NO; c++) begin
      a_t[c*8 +: 8] = 8'(tog_cnt[c] - s_tog[c]);
      a_r[c*8 +: 8] = 8'(rst_cnt[c] - s_rst[c]);
      x_t[c*8 +: 8] = {7'd0, e_tog[c]};
      x_r[c*8 +: 8] = {7'd0, e_rst[c]};
    end
    check({nm, " cmd_ok pulses"},  VW'(ok_cnt - s_ok), VW'(e_ok));
    check({nm, " cmd_err pulses"}, VW'(err_cnt - s_err), VW'(e_err));
    check({nm, " tog_pulse"},      VW'(a_t), VW'(x_t));
    check({nm, " ch_rst_n"},       VW'(a_r), VW'(x_r));
    check({nm, " trig_cnt"},       bus.trig_cnt, e_trig);
    check({nm, " prescaler"},      bus.prescaler, e_presc);
    if (e_ok == 1) begin
      // Stop bit of the chk byte is sampled near 9.5 bit-times after its start edge.
      lat = ok_cyc - last_start;
      checks++;
      if (lat < 9 * BAUD + BAUD / 2 || lat > 10 * BAUD) begin
        errors++;
        $display("FAIL %s latency: got %0d cycles, required %0d..%0d", nm, lat,
                 9 * BAUD + BAUD / 2, 10 * BAUD);
      end
    end
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, " trig_cnt"},  bus.trig_cnt, T_DEF);
    check({nm, " prescaler"}, bus.prescaler, P_DEF);
    check({nm, " tog_pulse"}, VW'(bus.tog_pulse), '0);
    check({nm, " ch_rst_n"},  VW'(bus.ch_rst_n), VW'({CH_NO{1'b1}}));
    check({nm, " cmd_ok"},    VW'(bus.cmd_ok), '0);
    check({nm, " cmd_err"},   VW'(bus.cmd_err), '0);
  endtask

  typedef struct {
    logic [FRAME_LEN*8-1:0] frame;
    int                     ok;
    int                     err;
    logic [CH_NO-1:0]       tog;
    logic [CH_NO-1:0]       rst;
    logic [VW-1:0]          trig;
    logic [VW-1:0]          presc;
  } vec_t;

  localparam logic [VW-1:0] T1 = 128'h00000020_00000020_00000020_00000040;
  localparam logic [VW-1:0] T6 = 128'h00000020_12345678_00000020_00000040;
  localparam logic [VW-1:0] TA = 128'h00000020_12345678_00000020_00000041;
  localparam logic [VW-1:0] P2 = 128'h0000C350_0000C350_00000064_0000C350;
  localparam logic [VW-1:0] P9 = 128'hA5A5A5A5_0000C350_00000064_0000C350;

  // Reference model state for the randomized phase.
  logic [31:0] m_trig[CH_NO];
  logic [31:0] m_presc[CH_NO];
  logic [7:0]  fr[FRAME_LEN];

  task automatic model_frame(output int e_ok, output int e_err,
                             output logic [CH_NO-1:0] e_tog, output logic [CH_NO-1:0] e_rst);
    logic [7:0]  x;
    logic [1:0]  op;
    int          ch;
    logic [31:0] d;
    x = 8'h00;
    for (int k = 1; k <= 5; k++) x = x ^ fr[k];
    op = fr[1][7:6];
    ch = int'(fr[1][1:0]);
    d  = {fr[2], fr[3], fr[4], fr[5]};
    e_tog = '0;
    e_rst = '0;
    e_ok  = (fr[6] == x && op != 2'b11 && ch < CH_NO) ? 1 : 0;
    e_err = 1 - e_ok;
    if (e_ok == 1) begin
      case (op)
        2'b00: m_trig[ch]  = d;
        2'b01: m_presc[ch] = d;
        default: begin
          e_tog[ch] = d[0];
          e_rst[ch] = d[1];
        end
      endcase
    end
  endtask

  vec_t tbl[9];

  initial begin
    logic [FRAME_LEN*8-1:0] f;
    logic [VW-1:0] et, ep;
    logic [7:0] jb;
    int e_ok, e_err;
    logic [CH_NO-1:0] e_tog, e_rst;

    tbl[0] = '{56'hA5_00_00000040_40, 1, 0, 4'b0000, 4'b0000, T1, P_DEF};
    tbl[1] = '{56'hA5_41_00000064_25, 1, 0, 4'b0000, 4'b0000, T1, P2};
    tbl[2] = '{56'hA5_41_00000064_26, 0, 1, 4'b0000, 4'b0000, T1, P2};
    tbl[3] = '{56'hA5_83_00000003_80, 1, 0, 4'b1000, 4'b1000, T1, P2};
    tbl[4] = '{56'hA5_C0_00000000_C0, 0, 1, 4'b0000, 4'b0000, T1, P2};
    tbl[5] = '{56'hA5_02_12345678_0A, 1, 0, 4'b0000, 4'b0000, T6, P2};
    tbl[6] = '{56'hA5_81_00000001_80, 1, 0, 4'b0010, 4'b0000, T6, P2};
    tbl[7] = '{56'hA5_82_000000FE_7C, 1, 0, 4'b0000, 4'b0100, T6, P2};
    tbl[8] = '{56'hA5_43_A5A5A5A5_43, 1, 0, 4'b0000, 4'b0000, T6, P9};

    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;
    idle_bits(1);

    for (int i = 0; i < 9; i++) begin
      snap();
      send_frame(tbl[i].frame);
      idle_bits(2);
      check_frame($sformatf("row%0d", i), tbl[i].ok, tbl[i].err, tbl[i].tog, tbl[i].rst,
                  tbl[i].trig, tbl[i].presc);
    end

    // Bad stop bit mid-frame aborts; a following good frame is accepted.
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b0);
    idle_bits(2);
    check_frame("framing", 0, 1, '0, '0, T6, P9);
    snap();
    send_frame(56'hA5_00_00000041_41);
    idle_bits(2);
    check_frame("after framing", 1, 0, '0, '0, TA, P9);

    // Short low glitch, then junk bytes before the sync byte.
    snap();
    bus.rx = 1'b0;
    repeat (BAUD / 2 - 3) @(posedge i_clk);
    #1;
    idle_bits(2);
    send_byte(8'h55, 1'b1);
    send_byte(8'h33, 1'b1);
    send_frame(56'hA5_00_00000040_40);
    idle_bits(2);
    check_frame("glitch+junk", 1, 0, '0, '0, T6, P9);

    // Inter-byte timeout: silent just before the limit, error just after.
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    idle_bits(TOB - 1);
    check("pre-timeout cmd_err", VW'(err_cnt - s_err), '0);
    idle_bits(2);
    check_frame("timeout", 0, 1, '0, '0, T6, P9);

    // Reset in the middle of a frame.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_state("mid-frame reset");
    rst_n = 1'b1;
    idle_bits(1);
    snap();
    send_frame(56'hA5_00_00000040_40);
    idle_bits(2);
    check_frame("after reset", 1, 0, '0, '0, T1, P_DEF);

    // Randomized frames against the model.
    for (int c = 0; c < CH_NO; c++) begin
      m_trig[c]  = 32'h20;
      m_presc[c] = 32'hC350;
    end
    m_trig[0] = 32'h40;
    for (int n = 0; n < 16; n++) begin
      snap();
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        do jb = 8'($urandom_range(0, 255)); while (jb == SYNC_BYTE);
        send_byte(jb, 1'b1);
      end
      fr[0] = SYNC_BYTE;
      fr[1] = 8'($urandom);
      for (int k = 2; k <= 5; k++) fr[k] = 8'($urandom);
      fr[6] = fr[1] ^ fr[2] ^ fr[3] ^ fr[4] ^ fr[5];
      if ($urandom_range(0, 3) == 0) fr[6] = fr[6] ^ 8'($urandom_range(1, 255));
      for (int k = 0; k < FRAME_LEN; k++) f[(FRAME_LEN - 1 - k)*8 +: 8] = fr[k];
      model_frame(e_ok, e_err, e_tog, e_rst);
      send_frame(f);
      idle_bits(2);
      for (int c = 0; c < CH_NO; c++) begin
        et[c*32 +: 32] = m_trig[c];
        ep[c*32 +: 32] = m_presc[c];
      end
      check_frame($sformatf("rand%0d", n), e_ok, e_err, e_tog, e_rst, et, ep);
    end

    check("updates outside cmd_ok", VW'(bad_cnt), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
